// File: rtl/cmp_accum_pkg.sv
// Shared types and helpers for the compare-and-accumulate pipeline.
package cmp_accum_pkg;

    typedef enum logic [1:0] {
        CODE_LT    = 2'd0,
        CODE_GT    = 2'd1,
        CODE_EQ    = 2'd2,
        CODE_MATCH = 2'd3
    } cmp_code_e;

    // a + 2*b needs two bits beyond the operand width
    function automatic int sum_width(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/cmp_accum_lane.sv
// One channel of stage 2: classify, add a + 2*b into the running
// accumulator, wrap or clamp on carry-out, keep the sticky overflow.
module cmp_accum_lane
    import cmp_accum_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ACC_W = 24,
    parameter bit SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output cmp_code_e        code,
    output logic [ACC_W-1:0] acc_new,
    output logic             ovf_new
);
    localparam int SUM_W = sum_width(WIDTH);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] acc_base;
    logic             ovf_base;
    logic [SUM_W-1:0] sum;
    logic [ACC_W:0]   raw;

    // Clear takes effect before a coincident load, so the beat sees acc = 0.
    always_comb begin
        acc_base = clear ? '0 : acc_q;
        ovf_base = clear ? 1'b0 : ovf_q;
        sum      = SUM_W'(a) + (SUM_W'(b) << 1);
        raw      = (ACC_W+1)'(acc_base) + (ACC_W+1)'(sum);
        if (SAT && raw[ACC_W]) begin
            acc_new = '1;
        end else begin
            acc_new = raw[ACC_W-1:0];
        end
        ovf_new = ovf_base | raw[ACC_W];

        if (a > b) begin
            code = CODE_GT;
        end else if (a == b) begin
            code = CODE_EQ;
        end else if (a == acc_base[WIDTH-1:0]) begin
            code = CODE_MATCH;
        end else begin
            code = CODE_LT;
        end

        acc_d = acc_base;
        ovf_d = ovf_base;
        if (load) begin
            acc_d = acc_new;
            ovf_d = ovf_new;
        end
    end

    // Accumulator and sticky overflow registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

endmodule

// File: rtl/cmp_accum.sv
// Multi-channel compare-and-accumulate: S1 operand registers, per-lane
// S2 datapath, output registers, and valid/ready pipeline control.
module cmp_accum
    import cmp_accum_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int NUM_CH = 2,
    parameter int ACC_W  = WIDTH + 8,
    parameter bit SAT    = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_CH-1:0][WIDTH-1:0]  in_a,
    input  logic [NUM_CH-1:0][WIDTH-1:0]  in_b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_CH-1:0][1:0]        out_code,
    output logic [NUM_CH-1:0][ACC_W-1:0]  out_acc,
    output logic [NUM_CH-1:0]             out_ovf
);
    if (ACC_W < WIDTH + 2) begin : g_acc_w_check
        $error("cmp_accum: ACC_W must be at least WIDTH+2");
    end

    logic                         s1_valid_q, s1_valid_d;
    logic [NUM_CH-1:0][WIDTH-1:0] s1_a_q, s1_a_d;
    logic [NUM_CH-1:0][WIDTH-1:0] s1_b_q, s1_b_d;
    logic                         out_valid_q, out_valid_d;
    logic [NUM_CH-1:0][1:0]       out_code_q, out_code_d;
    logic [NUM_CH-1:0][ACC_W-1:0] out_acc_q, out_acc_d;
    logic [NUM_CH-1:0]            out_ovf_q, out_ovf_d;

    logic                         s2_adv, s1_adv, s2_load;
    logic [NUM_CH-1:0][1:0]       lane_code;
    logic [NUM_CH-1:0][ACC_W-1:0] lane_acc;
    logic [NUM_CH-1:0]            lane_ovf;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        cmp_accum_lane #(
            .WIDTH (WIDTH),
            .ACC_W (ACC_W),
            .SAT   (SAT)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .clear   (clear),
            .load    (s2_load),
            .a       (s1_a_q[i]),
            .b       (s1_b_q[i]),
            .code    (lane_code[i]),
            .acc_new (lane_acc[i]),
            .ovf_new (lane_ovf[i])
        );
    end

    // Flow control: ready depends only on downstream state, never on in_valid.
    always_comb begin
        s2_adv   = !out_valid_q || out_ready;
        s1_adv   = !s1_valid_q || s2_adv;
        in_ready = s1_adv && !rst;
        s2_load  = s1_valid_q && s2_adv;

        s1_valid_d  = s1_adv ? in_valid : s1_valid_q;
        s1_a_d      = (s1_adv && in_valid) ? in_a : s1_a_q;
        s1_b_d      = (s1_adv && in_valid) ? in_b : s1_b_q;
        out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
        out_code_d  = s2_load ? lane_code : out_code_q;
        out_acc_d   = s2_load ? lane_acc : out_acc_q;
        out_ovf_d   = s2_load ? lane_ovf : out_ovf_q;
    end

    // Pipeline and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            out_valid_q <= 1'b0;
            out_code_q  <= '0;
            out_acc_q   <= '0;
            out_ovf_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            out_valid_q <= out_valid_d;
            out_code_q  <= out_code_d;
            out_acc_q   <= out_acc_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_code  = out_code_q;
    assign out_acc   = out_acc_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_cmp_accum.sv
// Scoreboard bench for cmp_accum: a 2-channel 24-bit instance plus
// 1-channel 18-bit saturating and wrapping instances.
module tb_cmp_accum;
    import cmp_accum_pkg::*;

    typedef struct packed {
        logic [1:0]  c1;
        logic [1:0]  c0;
        logic [23:0] a1;
        logic [23:0] a0;
        logic        o1;
        logic        o0;
    } exp_t;

    typedef struct packed {
        logic [1:0]  c;
        logic [17:0] acc_s;
        logic        ovf_s;
        logic [17:0] acc_w;
        logic        ovf_w;
    } xexp_t;

    logic clk = 1'b0;
    logic rst;
    logic clear;
    logic in_valid;
    logic in_ready;
    logic [1:0][15:0] in_a, in_b;
    logic out_valid;
    logic out_ready;
    logic [1:0][1:0]  out_code;
    logic [1:0][23:0] out_acc;
    logic [1:0]       out_ovf;

    logic x_clear, x_in_valid, x_out_ready;
    logic x_in_ready_s, x_in_ready_w;
    logic [0:0][15:0] x_a, x_b;
    logic x_out_valid_s, x_out_valid_w;
    logic [0:0][1:0]  x_code_s, x_code_w;
    logic [0:0][17:0] x_acc_s, x_acc_w;
    logic [0:0]       x_ovf_s, x_ovf_w;

    int total = 0;
    int bad = 0;
    exp_t  exp_q[$];
    xexp_t xq[$];

    always #5 clk = ~clk;

    cmp_accum #(.WIDTH(16), .NUM_CH(2), .ACC_W(24), .SAT(1'b0)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_code(out_code), .out_acc(out_acc), .out_ovf(out_ovf)
    );

    cmp_accum #(.WIDTH(16), .NUM_CH(1), .ACC_W(18), .SAT(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .clear(x_clear), .in_valid(x_in_valid), .in_ready(x_in_ready_s),
        .in_a(x_a), .in_b(x_b), .out_valid(x_out_valid_s), .out_ready(x_out_ready),
        .out_code(x_code_s), .out_acc(x_acc_s), .out_ovf(x_ovf_s)
    );

    cmp_accum #(.WIDTH(16), .NUM_CH(1), .ACC_W(18), .SAT(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .clear(x_clear), .in_valid(x_in_valid), .in_ready(x_in_ready_w),
        .in_a(x_a), .in_b(x_b), .out_valid(x_out_valid_w), .out_ready(x_out_ready),
        .out_code(x_code_w), .out_acc(x_acc_w), .out_ovf(x_ovf_w)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, want);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] c0, input logic [23:0] a0, input logic o0,
                                input logic [1:0] c1, input logic [23:0] a1, input logic o1);
        exp_t e;
        e.c0 = c0; e.a0 = a0; e.o0 = o0;
        e.c1 = c1; e.a1 = a1; e.o1 = o1;
        return e;
    endfunction

    // Call at posedge+#1; returns at posedge+#1 just after the handshake edge.
    task automatic send(input logic [15:0] a0, input logic [15:0] b0,
                        input logic [15:0] a1, input logic [15:0] b1,
                        input logic push, input exp_t e);
        bit got = 0;
        in_a = {a1, a0};
        in_b = {b1, b0};
        in_valid = 1'b1;
        if (push) exp_q.push_back(e);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL send_timeout got=in_ready_low want=accept");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_x(input logic [15:0] a, input logic [15:0] b, input xexp_t e);
        bit got = 0;
        x_a = a;
        x_b = b;
        x_in_valid = 1'b1;
        xq.push_back(e);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (x_in_ready_s) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL send_x_timeout got=in_ready_low want=accept");
        end
        @(posedge clk);
        #1;
        x_in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat got=acc_%0h want=no_beat", out_acc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("beat_code", 64'(out_code), 64'({e.c1, e.c0}));
                chk("beat_acc",  64'(out_acc),  64'({e.a1, e.a0}));
                chk("beat_ovf",  64'(out_ovf),  64'({e.o1, e.o0}));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && x_out_valid_s && x_out_ready) begin
            if (xq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL x_unexpected_beat got=acc_%0h want=no_beat", x_acc_s);
            end else begin
                xexp_t e;
                e = xq.pop_front();
                chk("x_valid_wrap", 64'(x_out_valid_w), 64'(1));
                chk("x_code_sat",   64'(x_code_s), 64'(e.c));
                chk("x_code_wrap",  64'(x_code_w), 64'(e.c));
                chk("x_acc_sat",    64'(x_acc_s),  64'(e.acc_s));
                chk("x_acc_wrap",   64'(x_acc_w),  64'(e.acc_w));
                chk("x_ovf_sat",    64'(x_ovf_s),  64'(e.ovf_s));
                chk("x_ovf_wrap",   64'(x_ovf_w),  64'(e.ovf_w));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    logic [15:0] bp_a0 [4];
    logic [15:0] bp_b0 [4];
    logic [15:0] bp_a1 [4];
    logic [15:0] bp_b1 [4];

    initial begin
        int idx;
        int n_out;
        int cycles;
        bit take;

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        x_clear = 1'b0; x_in_valid = 1'b0; x_a = '0; x_b = '0; x_out_ready = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_acc", 64'(out_acc), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", 64'(in_ready), 64'(1));
        @(posedge clk); #1;

        // basic: latency and classification
        send(16'd5, 16'd3, 16'd3, 16'd3, 1'b1, mk(CODE_GT, 24'd11, 1'b0, CODE_EQ, 24'd9, 1'b0));
        @(negedge clk);
        chk("latency_early", 64'(out_valid), 64'(0));
        @(negedge clk);
        chk("latency_on_time", 64'(out_valid), 64'(1));
        @(posedge clk); #1;
        send(16'd11, 16'd20, 16'd1, 16'd0, 1'b1, mk(CODE_MATCH, 24'd62, 1'b0, CODE_GT, 24'd10, 1'b0));
        repeat (3) @(posedge clk);
        #1;

        // backpressure: 4 beats offered against a stalled consumer
        bp_a0 = '{16'd1, 16'd0, 16'd63, 16'd4};
        bp_b0 = '{16'd0, 16'd0, 16'd100, 16'd4};
        bp_a1 = '{16'd2, 16'd3, 16'd7, 16'd1};
        bp_b1 = '{16'd0, 16'd5, 16'd0, 16'd2};
        exp_q.push_back(mk(CODE_GT,    24'd63,  1'b0, CODE_GT, 24'd12, 1'b0));
        exp_q.push_back(mk(CODE_EQ,    24'd63,  1'b0, CODE_LT, 24'd25, 1'b0));
        exp_q.push_back(mk(CODE_MATCH, 24'd326, 1'b0, CODE_GT, 24'd32, 1'b0));
        exp_q.push_back(mk(CODE_EQ,    24'd338, 1'b0, CODE_LT, 24'd37, 1'b0));
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (idx < 4);
            if (idx < 4) begin
                in_a = {bp_a1[idx], bp_a0[idx]};
                in_b = {bp_b1[idx], bp_b0[idx]};
            end
            @(negedge clk);
            take = in_valid && in_ready;
            @(posedge clk); #1;
            if (take) idx++;
        end
        @(negedge clk);
        chk("bp_accepted", 64'(idx), 64'(2));
        chk("bp_in_ready", 64'(in_ready), 64'(0));
        chk("bp_hold_valid", 64'(out_valid), 64'(1));
        chk("bp_hold_acc", 64'(out_acc), 64'({24'd12, 24'd63}));
        chk("bp_hold_code", 64'(out_code), 64'({2'd1, 2'd1}));
        @(posedge clk); #1;
        out_ready = 1'b1;
        n_out = 0;
        cycles = 0;
        while (n_out < 4 && cycles < 20) begin
            in_valid = (idx < 4);
            if (idx < 4) begin
                in_a = {bp_a1[idx], bp_a0[idx]};
                in_b = {bp_b1[idx], bp_b0[idx]};
            end
            @(negedge clk);
            if (out_valid) n_out++;
            take = in_valid && in_ready;
            @(posedge clk); #1;
            if (take) idx++;
            cycles++;
        end
        in_valid = 1'b0;
        chk("bp_drain_cycles", 64'(cycles), 64'(4));

        // clear coincident with an S2 load: MATCH must compare against 0
        send(16'd338, 16'd400, 16'd0, 16'd5, 1'b1, mk(CODE_LT, 24'd1138, 1'b0, CODE_MATCH, 24'd10, 1'b0));
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // clear during a stall leaves held outputs alone
        out_ready = 1'b0;
        send(16'd2, 16'd0, 16'd1, 16'd0, 1'b1, mk(CODE_GT, 24'd1140, 1'b0, CODE_GT, 24'd11, 1'b0));
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        chk("stall_clr_valid", 64'(out_valid), 64'(1));
        chk("stall_clr_acc", 64'(out_acc), 64'({24'd11, 24'd1140}));
        chk("stall_clr_code", 64'(out_code), 64'({2'd1, 2'd1}));
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(16'd5, 16'd1, 16'd0, 16'd0, 1'b1, mk(CODE_GT, 24'd7, 1'b0, CODE_EQ, 24'd0, 1'b0));
        repeat (3) @(posedge clk);
        #1;

        // reset mid-stream with two beats held
        out_ready = 1'b0;
        send(16'd1, 16'd1, 16'd1, 16'd1, 1'b0, '0);
        send(16'd2, 16'd2, 16'd2, 16'd2, 1'b0, '0);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid", 64'(out_valid), 64'(0));
        chk("midrst_acc", 64'(out_acc), 64'(0));
        chk("midrst_code", 64'(out_code), 64'(0));
        chk("midrst_ovf", 64'(out_ovf), 64'(0));
        chk("midrst_in_ready", 64'(in_ready), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_in_ready", 64'(in_ready), 64'(1));
        chk("postrst_valid", 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(16'd3, 16'd4, 16'd9, 16'd2, 1'b1, mk(CODE_LT, 24'd11, 1'b0, CODE_GT, 24'd13, 1'b0));
        repeat (3) @(posedge clk);
        #1;

        // 18-bit saturate vs wrap, then clear coincident with a load
        send_x(16'hFFFF, 16'hFFFF, '{c: CODE_EQ, acc_s: 18'h2FFFD, ovf_s: 1'b0, acc_w: 18'h2FFFD, ovf_w: 1'b0});
        send_x(16'hFFFF, 16'hFFFF, '{c: CODE_EQ, acc_s: 18'h3FFFF, ovf_s: 1'b1, acc_w: 18'h1FFFA, ovf_w: 1'b1});
        send_x(16'd108,  16'hFFFF, '{c: CODE_LT, acc_s: 18'h3FFFF, ovf_s: 1'b1, acc_w: 18'd100, ovf_w: 1'b1});
        send_x(16'd2,    16'd1,    '{c: CODE_GT, acc_s: 18'd4, ovf_s: 1'b0, acc_w: 18'd4, ovf_w: 1'b0});
        x_clear = 1'b1;
        @(posedge clk); #1;
        x_clear = 1'b0;

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("main_queue_drained", 64'(exp_q.size()), 64'(0));
        chk("aux_queue_drained", 64'(xq.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
